// File: rtl/ptmch_trg_seq.sv
// Four-channel trigger pulse sequencer: programmable delay/width per channel within a frame.
// Define PTMCH_TRG_RPT_EN to honour the RPT register (RPT+1 back-to-back frames per START).

module ptmch_trg_ch #(
   parameter int DLY_W = 16,
   parameter int WID_W = 8
) (
   input  logic             run,
   input  logic [DLY_W-1:0] t,
   input  logic [DLY_W-1:0] dly,
   input  logic [WID_W-1:0] wid,
   output logic             hit
);
   logic [DLY_W:0] t_x, lo_x, hi_x;

   // One extra bit so DLY+WID near the top of the range cannot wrap.
   assign t_x  = {1'b0, t};
   assign lo_x = {1'b0, dly};
   assign hi_x = lo_x + {{(DLY_W+1-WID_W){1'b0}}, wid};
   assign hit  = run && (wid != '0) && (t_x >= lo_x) && (t_x < hi_x);
endmodule

module ptmch_trg_seq #(
   parameter int NCH   = 4,
   parameter int DLY_W = 16,
   parameter int WID_W = 8,
   parameter int RPT_W = 8
) (
   input  logic             CLK160M,
   input  logic             RESET,
   input  logic             CFG_WE,
   input  logic [3:0]       CFG_ADDR,
   input  logic [15:0]      CFG_WDATA,
   input  logic             START,
   input  logic             ABORT,
   output logic [NCH-1:0]   TRG_PLS,
   output logic             BUSY,
   output logic             DONE,
   output logic             CFG_ERR,
   output logic [RPT_W-1:0] FRAME_CNT
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t                      state_q, state_d;
   logic [NCH-1:0][DLY_W-1:0]   dly_q, dly_d;
   logic [NCH-1:0][WID_W-1:0]   wid_q, wid_d;
   logic [DLY_W-1:0]            per_q, per_d;
   logic [DLY_W-1:0]            t_q, t_d;
   logic [RPT_W-1:0]            fc_q, fc_d;
   logic                        start_q, start_d;
   logic [NCH-1:0]              trg_q, trg_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        err_q, err_d;
`ifdef PTMCH_TRG_RPT_EN
   logic [RPT_W-1:0]            rpt_q, rpt_d;
   logic [RPT_W-1:0]            left_q, left_d;
`endif

   logic [NCH-1:0] hit;
   logic           run;
   logic           go, go_err, cfg_blk;

   assign run = (state_q == S_RUN);

   for (genvar n = 0; n < NCH; n++) begin : g_ch
      ptmch_trg_ch #(.DLY_W(DLY_W), .WID_W(WID_W)) u_ch (
         .run (run),
         .t   (t_q),
         .dly (dly_q[n]),
         .wid (wid_q[n]),
         .hit (hit[n])
      );
   end

   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      wid_d   = wid_q;
      per_d   = per_q;
      t_d     = t_q;
      fc_d    = fc_q;
      err_d   = 1'b0;
`ifdef PTMCH_TRG_RPT_EN
      rpt_d   = rpt_q;
      left_d  = left_q;
`endif

      // START is registered once; a start pending in IDLE is taken on the next clock.
      start_d = START && !ABORT && !busy_q && (state_q == S_IDLE);
      go      = (state_q == S_IDLE) && start_q && !ABORT && (per_q != '0);
      go_err  = (state_q == S_IDLE) && start_q && !ABORT && (per_q == '0);
      cfg_blk = (state_q != S_IDLE) || busy_q || go;

      if (go_err) err_d = 1'b1;

      if (CFG_WE) begin
         if (cfg_blk) begin
            err_d = 1'b1;
         end else if (CFG_ADDR[3:2] == 2'b00) begin
            dly_d[CFG_ADDR[1:0]] = CFG_WDATA[DLY_W-1:0];
         end else if (CFG_ADDR[3:2] == 2'b01) begin
            wid_d[CFG_ADDR[1:0]] = CFG_WDATA[WID_W-1:0];
         end else if (CFG_ADDR == 4'd8) begin
            per_d = CFG_WDATA[DLY_W-1:0];
         end else if (CFG_ADDR == 4'd9) begin
`ifdef PTMCH_TRG_RPT_EN
            rpt_d = CFG_WDATA[RPT_W-1:0];
`endif
         end else begin
            err_d = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d = S_RUN;
               t_d     = '0;
               fc_d    = '0;
`ifdef PTMCH_TRG_RPT_EN
               left_d  = rpt_q;
`endif
            end
         end
         S_RUN: begin
            t_d = t_q + DLY_W'(1);
            if (t_q == per_q - DLY_W'(1)) begin
               fc_d = (fc_q == '1) ? fc_q : fc_q + RPT_W'(1);
               t_d  = '0;
`ifdef PTMCH_TRG_RPT_EN
               if (left_q != '0) left_d = left_q - RPT_W'(1);
               else              state_d = S_FIN;
`else
               state_d = S_FIN;
`endif
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Abort wins over start, frame end and FIN; the frame count is frozen.
      if (ABORT) begin
         state_d = S_IDLE;
         t_d     = '0;
         fc_d    = fc_q;
      end

      trg_d  = ABORT ? '0 : hit;
      busy_d = !ABORT && (state_q != S_IDLE);
      done_d = !ABORT && (state_q == S_FIN);
   end

   always_ff @(posedge CLK160M) begin
      if (RESET) begin
         state_q <= S_IDLE;
         dly_q   <= '0;
         wid_q   <= '0;
         per_q   <= '0;
         t_q     <= '0;
         fc_q    <= '0;
         start_q <= 1'b0;
         trg_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef PTMCH_TRG_RPT_EN
         rpt_q   <= '0;
         left_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         wid_q   <= wid_d;
         per_q   <= per_d;
         t_q     <= t_d;
         fc_q    <= fc_d;
         start_q <= start_d;
         trg_q   <= trg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef PTMCH_TRG_RPT_EN
         rpt_q   <= rpt_d;
         left_q  <= left_d;
`endif
      end
   end

   assign TRG_PLS   = trg_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign CFG_ERR   = err_q;
   assign FRAME_CNT = fc_q;
endmodule

// File: tb/tb_ptmch_trg_seq.sv
// Self-checking bench for ptmch_trg_seq: directed scenarios plus random configs vs a frame-level model.

module tb_ptmch_trg_seq;
`ifdef PTMCH_TRG_RPT_EN
   localparam bit RPT_EN = 1'b1;
`else
   localparam bit RPT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        RESET = 1'b1;
   logic        CFG_WE = 1'b0;
   logic [3:0]  CFG_ADDR = '0;
   logic [15:0] CFG_WDATA = '0;
   logic        START = 1'b0;
   logic        ABORT = 1'b0;
   logic [3:0]  TRG_PLS;
   logic        BUSY, DONE, CFG_ERR;
   logic [7:0]  FRAME_CNT;

   int n_vec = 0;
   int n_err = 0;

   int sh_dly[4];
   int sh_wid[4];
   int sh_per;
   int sh_rpt;
   int sh_fc;

   ptmch_trg_seq dut (
      .CLK160M   (clk),
      .RESET     (RESET),
      .CFG_WE    (CFG_WE),
      .CFG_ADDR  (CFG_ADDR),
      .CFG_WDATA (CFG_WDATA),
      .START     (START),
      .ABORT     (ABORT),
      .TRG_PLS   (TRG_PLS),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .CFG_ERR   (CFG_ERR),
      .FRAME_CNT (FRAME_CNT)
   );

   always #3 clk = ~clk;

   // Frames completed c clocks after the START-sampling edge (run begins one clock later).
   function automatic int fc_nom(input int c);
      int f, done_fr;
      if (c < 1) return sh_fc;
      f = RPT_EN ? sh_rpt + 1 : 1;
      done_fr = (c - 1) / sh_per;
      if (done_fr > f) done_fr = f;
      if (done_fr > 255) done_fr = 255;
      return done_fr;
   endfunction

   function automatic void exp_at(input int c, input int ab, output logic [3:0] trg,
                                  output logic busy, output logic done, output logic [7:0] fc);
      int f, tot, j, t;
      f   = RPT_EN ? sh_rpt + 1 : 1;
      tot = f * sh_per;
      trg = '0;
      if (ab > 0 && c >= ab) begin
         busy = 1'b0;
         done = 1'b0;
         fc   = 8'(fc_nom(ab - 1));
      end else begin
         j = c - 2;
         if (j >= 0 && j < tot) begin
            t = j % sh_per;
            for (int n = 0; n < 4; n++)
               trg[n] = (sh_wid[n] != 0) && (t >= sh_dly[n]) && (t < sh_dly[n] + sh_wid[n]);
         end
         busy = (c >= 2) && (c <= tot + 2);
         done = (c == tot + 2);
         fc   = 8'(fc_nom(c));
      end
   endfunction

   task automatic wr(input int a, input int d, input bit exp_err);
      CFG_WE    = 1'b1;
      CFG_ADDR  = 4'(a);
      CFG_WDATA = 16'(d);
      @(posedge clk); #1;
      CFG_WE = 1'b0;
      n_vec++;
      if (CFG_ERR !== exp_err) begin
         n_err++;
         $display("FAIL wr_err addr=%0d got=%b exp=%b", a, CFG_ERR, exp_err);
      end
      if (!exp_err) begin
         if (a < 4)       sh_dly[a]   = d & 16'hFFFF;
         else if (a < 8)  sh_wid[a-4] = d & 8'hFF;
         else if (a == 8) sh_per      = d & 16'hFFFF;
         else if (a == 9) sh_rpt      = d & 8'hFF;
      end
   endtask

   task automatic cfg(input int d0, input int w0, input int d1, input int w1,
                      input int d2, input int w2, input int d3, input int w3, input int per);
      wr(0, d0, 1'b0); wr(4, w0, 1'b0);
      wr(1, d1, 1'b0); wr(5, w1, 1'b0);
      wr(2, d2, 1'b0); wr(6, w2, 1'b0);
      wr(3, d3, 1'b0); wr(7, w3, 1'b0);
      wr(8, per, 1'b0);
   endtask

   // ab: cycle whose edge samples ABORT (0 = none); wr_c: cycle whose edge samples a busy write.
   task automatic run_chk(input string nm, input int ab, input int wr_c);
      int f, tot, last;
      logic [3:0] e_trg;
      logic e_busy, e_done, e_err;
      logic [7:0] e_fc;
      f    = RPT_EN ? sh_rpt + 1 : 1;
      tot  = f * sh_per;
      last = (ab > 0) ? ab + 3 : tot + 4;
      START = 1'b1;
      @(posedge clk); #1;
      START = 1'b0;
      if (ab == 1) ABORT = 1'b1;
      if (wr_c == 1) begin CFG_WE = 1'b1; CFG_ADDR = 4'd8; CFG_WDATA = 16'd20; end
      for (int c = 1; c <= last; c++) begin
         @(posedge clk); #1;
         ABORT  = 1'b0;
         CFG_WE = 1'b0;
         exp_at(c, ab, e_trg, e_busy, e_done, e_fc);
         e_err = (c == wr_c);
         n_vec++;
         if (TRG_PLS !== e_trg || BUSY !== e_busy || DONE !== e_done ||
             FRAME_CNT !== e_fc || CFG_ERR !== e_err) begin
            n_err++;
            $display("FAIL %s c=%0d got trg=%b busy=%b done=%b fc=%0d err=%b exp trg=%b busy=%b done=%b fc=%0d err=%b",
                     nm, c, TRG_PLS, BUSY, DONE, FRAME_CNT, CFG_ERR, e_trg, e_busy, e_done, e_fc, e_err);
         end
         if (c + 1 == ab) ABORT = 1'b1;
         if (c + 1 == wr_c) begin CFG_WE = 1'b1; CFG_ADDR = 4'd8; CFG_WDATA = 16'd20; end
      end
      sh_fc = fc_nom((ab > 0) ? ab - 1 : last);
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (TRG_PLS !== 4'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || CFG_ERR !== 1'b0 || FRAME_CNT !== 8'd0) begin
         n_err++;
         $display("FAIL reset got trg=%b busy=%b done=%b err=%b fc=%0d exp all 0",
                  TRG_PLS, BUSY, DONE, CFG_ERR, FRAME_CNT);
      end
      RESET = 1'b0;
      for (int n = 0; n < 4; n++) begin sh_dly[n] = 0; sh_wid[n] = 0; end
      sh_per = 0; sh_rpt = 0; sh_fc = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_per_zero();
      START = 1'b1;
      @(posedge clk); #1;
      START = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1;
         n_vec++;
         if (CFG_ERR !== (c == 1) || BUSY !== 1'b0 || DONE !== 1'b0) begin
            n_err++;
            $display("FAIL per_zero c=%0d got err=%b busy=%b done=%b exp err=%b busy=0 done=0",
                     c, CFG_ERR, BUSY, DONE, c == 1);
         end
      end
   endtask

   task automatic test_bad_addr();
      for (int a = 10; a < 16; a++) wr(a, int'($urandom), 1'b1);
      @(posedge clk); #1;
      n_vec++;
      if (CFG_ERR !== 1'b0) begin
         n_err++;
         $display("FAIL bad_addr_clear got=%b exp=0", CFG_ERR);
      end
   endtask

   task automatic test_basic();
      cfg(3, 2, 0, 0, 0, 0, 0, 0, 10);
      run_chk("basic", 0, 0);
   endtask

   task automatic test_channels();
      cfg(0, 1, 4, 3, 8, 5, 2, 0, 10);
      run_chk("channels", 0, 0);
   endtask

   task automatic test_busy_write();
      run_chk("busy_wr", 0, 4);
      run_chk("busy_wr_after", 0, 0);
      wr(8, 0, 1'b0);
      test_per_zero();
      wr(8, 10, 1'b0);
   endtask

   task automatic test_abort();
      cfg(0, 1, 4, 3, 8, 5, 2, 0, 10);
      run_chk("abort_ch1", 8, 0);
      START = 1'b1;
      ABORT = 1'b1;
      @(posedge clk); #1;
      START = 1'b0;
      ABORT = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         n_vec++;
         if (BUSY !== 1'b0 || DONE !== 1'b0 || TRG_PLS !== 4'b0 || CFG_ERR !== 1'b0 ||
             FRAME_CNT !== 8'(sh_fc)) begin
            n_err++;
            $display("FAIL start_abort c=%0d got busy=%b done=%b trg=%b err=%b fc=%0d exp idle fc=%0d",
                     c, BUSY, DONE, TRG_PLS, CFG_ERR, FRAME_CNT, sh_fc);
         end
      end
   endtask

   task automatic test_repeat();
      wr(9, 2, 1'b0);
      cfg(1, 1, 0, 0, 0, 0, 0, 0, 10);
      run_chk("repeat", 0, 0);
      wr(9, 0, 1'b0);
   endtask

   task automatic test_random();
      int per, tot, ab;
      for (int i = 0; i < 24; i++) begin
         per = int'($urandom_range(1, 24));
         for (int n = 0; n < 4; n++) begin
            wr(n, int'($urandom_range(0, per + 3)), 1'b0);
            wr(n + 4, int'({$urandom_range(0, 255), 8'($urandom_range(0, 8))}) & 16'hFFFF, 1'b0);
         end
         wr(8, per, 1'b0);
         wr(9, int'($urandom_range(0, 3)), 1'b0);
         tot = (RPT_EN ? sh_rpt + 1 : 1) * per;
         ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, tot + 2)) : 0;
         run_chk("random", ab, 0);
      end
   endtask

   initial begin
      test_reset();
      test_per_zero();
      test_bad_addr();
      test_basic();
      test_channels();
      test_busy_write();
      test_abort();
      test_repeat();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
